mux_scan_ctrl: RTL and testbench

//   Upstream select sequencer for the 4:1 mux stage. Drives S1/S0 through

---
 rtl/mux_pkg.sv | 38 +++
 rtl/mux_scan_ctrl_if.sv | 28 ++
 rtl/mux_dwell_cnt.sv | 38 +++
 rtl/mux_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux select sequencer.
// Channel-pick helper supports the optional MUX_SCAN_MASK_EN channel mask.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int unsigned NUM_CH = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    typedef struct packed {
        logic       found;
        logic [1:0] ch;
    } ch_pick_t;

    // Lowest enabled channel above 'from' (or at 'from' when incl is set).
    function automatic ch_pick_t pick_ch(input logic [NUM_CH-1:0] mask,
                                         input logic [1:0]        from,
                                         input logic              incl);
        ch_pick_t r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
                r.found = 1'b1;
                r.ch    = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side signals of the scan sequencer.
// ch_mask exists only when MUX_SCAN_MASK_EN is defined.
interface mux_scan_ctrl_if;

    logic       start;
    logic       cont;
    logic       f;
    logic       s1;
    logic       s0;
    logic [3:0] q;
    logic       valid;
    logic       ready;
    logic       busy;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0] ch_mask;

    modport master (input start, cont, f, ready, ch_mask,
                    output s1, s0, q, valid, busy);
    modport slave  (output start, cont, f, ready, ch_mask,
                    input s1, s0, q, valid, busy);
`else
    modport master (input start, cont, f, ready,
                    output s1, s0, q, valid, busy);
    modport slave  (output start, cont, f, ready,
                    input s1, s0, q, valid, busy);
`endif

endinterface

// File: rtl/mux_dwell_cnt.sv
// Dwell counter: load, decrement to zero and hold, registered zero flag.
module mux_dwell_cnt #(
    parameter int unsigned DW_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [DW_W-1:0] load_val_i,
    input  logic            dec_i,
    output logic            zero_o
);

    logic [DW_W-1:0] cnt_q, cnt_d;
    logic            zero_q, zero_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DW_W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for the 4:1 mux: steps S1/S0, samples F, hands Q downstream.
// Optional channel skipping is enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int unsigned DWELL = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.master bus
);

    localparam int unsigned      DW_W      = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0]  DW_RELOAD = DW_W'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] q_q, q_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] mask_in;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       cnt_load, cnt_dec, cnt_zero;
    ch_pick_t   first_pick, next_pick;

`ifdef MUX_SCAN_MASK_EN
    assign mask_in = bus.ch_mask;
`else
    assign mask_in = '1;
`endif

    assign first_pick = pick_ch(mask_in, CH_A, 1'b1);
    assign next_pick  = pick_ch(mask_q, sel_q, 1'b0);

    mux_dwell_cnt #(
        .DW_W (DW_W)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (DW_RELOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_SCAN;
            ST_SCAN: if ((mask_q == '0) || (cnt_zero && !next_pick.found)) state_d = ST_HOLD;
            ST_HOLD: if (valid_q && bus.ready) state_d = bus.cont ? ST_SCAN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; a scan start (re)loads mask, select and dwell.
    always_comb begin
        sel_d    = sel_q;
        q_d      = q_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                sel_d = CH_A;
                if (bus.start) begin
                    mask_d   = mask_in;
                    sel_d    = first_pick.ch;
                    cnt_load = 1'b1;
                end
            end
            ST_SCAN: begin
                if (mask_q == '0) begin
                    q_d     = '0;
                    valid_d = 1'b1;
                    sel_d   = CH_D;
                end else if (cnt_zero) begin
                    q_d[sel_q] = bus.f;
                    if (next_pick.found) begin
                        sel_d    = next_pick.ch;
                        cnt_load = 1'b1;
                    end else begin
                        q_d     = q_d & mask_q;
                        valid_d = 1'b1;
                        sel_d   = CH_D;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    if (bus.cont) begin
                        mask_d   = mask_in;
                        sel_d    = first_pick.ch;
                        cnt_load = 1'b1;
                    end else begin
                        sel_d = CH_A;
                    end
                end
            end
            default: begin
                sel_d   = CH_A;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= CH_A;
            q_q     <= '0;
            mask_q  <= '1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            q_q     <= q_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.q     = q_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl (DWELL=2); mask cases run when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] fvec;
    logic [3:0] exp_q[$];
    int         n_tests;
    int         n_fail;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(
        .DWELL (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural 4:1 mux driven by the DUT select lines.
    assign bus.f = fvec[{bus.s1, bus.s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] sel_now();
        return {30'd0, bus.s1, bus.s0};
    endfunction

    // Monitor: every accepted word is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got q=%b with no expected word queued", bus.q);
            end else begin
                automatic logic [3:0] e = exp_q.pop_front();
                chk("word_q", {28'd0, bus.q}, {28'd0, e});
                chk("word_sel", sel_now(), 32'd3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'($urandom);
        bus.cont  = 1'($urandom);
        bus.ready = 1'($urandom);
        fvec      = 4'($urandom);
`ifdef MUX_SCAN_MASK_EN
        bus.ch_mask = 4'($urandom);
`endif
        // Reset with random inputs
        repeat (3) tick();
        chk("rst_sel", sel_now(), 32'd0);
        chk("rst_q", {28'd0, bus.q}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.cont  = 1'b0;
        bus.ready = 1'b1;
`ifdef MUX_SCAN_MASK_EN
        bus.ch_mask = 4'hF;
`endif
        rst_n = 1'b1;
        tick();

        // Single shot: A,B,C,D = 1,0,1,1
        fvec = 4'b1101;
        exp_q.push_back(4'b1101);
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            chk("ss_sel", sel_now(), 32'(k / 2));
            chk("ss_valid_low", {31'd0, bus.valid}, 32'd0);
            chk("ss_busy", {31'd0, bus.busy}, 32'd1);
            tick();
        end
        chk("ss_valid_t8", {31'd0, bus.valid}, 32'd1);
        chk("ss_q", {28'd0, bus.q}, 32'hD);
        tick();
        chk("ss_valid_drop", {31'd0, bus.valid}, 32'd0);
        chk("ss_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("ss_idle_sel", sel_now(), 32'd0);

        // Backpressure
        bus.ready = 1'b0;
        fvec      = 4'b0110;
        exp_q.push_back(4'b0110);
        pulse_start();
        repeat (8) tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, bus.valid}, 32'd1);
            chk("bp_q", {28'd0, bus.q}, 32'h6);
            chk("bp_sel", sel_now(), 32'd3);
            if (k < 4) tick();
        end
        bus.ready = 1'b1;
        tick();
        chk("bp_valid_drop", {31'd0, bus.valid}, 32'd0);
        chk("bp_idle", {31'd0, bus.busy}, 32'd0);

        // Continuous: two back-to-back words
        bus.cont = 1'b1;
        fvec     = 4'b0000;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1111);
        pulse_start();
        repeat (8) tick();
        chk("ct_valid1", {31'd0, bus.valid}, 32'd1);
        fvec = 4'b1111;
        tick();
        chk("ct_restart_busy", {31'd0, bus.busy}, 32'd1);
        chk("ct_restart_sel", sel_now(), 32'd0);
        chk("ct_restart_valid", {31'd0, bus.valid}, 32'd0);
        repeat (7) tick();
        chk("ct_not_yet", {31'd0, bus.valid}, 32'd0);
        tick();
        chk("ct_valid2", {31'd0, bus.valid}, 32'd1);
        bus.cont = 1'b0;
        tick();
        chk("ct_idle", {31'd0, bus.busy}, 32'd0);

`ifdef MUX_SCAN_MASK_EN
        // Masked scan: only channels 1 and 3
        bus.ch_mask = 4'b1010;
        fvec        = 4'b1111;
        exp_q.push_back(4'b1010);
        pulse_start();
        bus.ch_mask = 4'hF;
        chk("mk_sel0", sel_now(), 32'd1);
        tick();
        chk("mk_sel1", sel_now(), 32'd1);
        tick();
        chk("mk_sel2", sel_now(), 32'd3);
        tick();
        chk("mk_sel3", sel_now(), 32'd3);
        chk("mk_valid_low", {31'd0, bus.valid}, 32'd0);
        tick();
        chk("mk_valid", {31'd0, bus.valid}, 32'd1);
        tick();
        chk("mk_idle", {31'd0, bus.busy}, 32'd0);
        // Empty mask completes at t+1
        bus.ch_mask = 4'b0000;
        exp_q.push_back(4'b0000);
        pulse_start();
        bus.ch_mask = 4'hF;
        chk("m0_busy", {31'd0, bus.busy}, 32'd1);
        chk("m0_valid_low", {31'd0, bus.valid}, 32'd0);
        tick();
        chk("m0_valid", {31'd0, bus.valid}, 32'd1);
        chk("m0_q", {28'd0, bus.q}, 32'd0);
        tick();
`endif

        // Reset mid-scan while sel==2
        fvec = 4'b1111;
        pulse_start();
        repeat (4) tick();
        chk("mr_sel2", sel_now(), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_sel", sel_now(), 32'd0);
        chk("mr_q", {28'd0, bus.q}, 32'd0);
        chk("mr_valid", {31'd0, bus.valid}, 32'd0);
        chk("mr_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fvec = 4'b1010;
        exp_q.push_back(4'b1010);
        pulse_start();
        repeat (7) tick();
        chk("mr_fresh_not_yet", {31'd0, bus.valid}, 32'd0);
        tick();
        chk("mr_fresh_valid", {31'd0, bus.valid}, 32'd1);
        chk("mr_fresh_q", {28'd0, bus.q}, 32'hA);
        tick();
        chk("mr_fresh_idle", {31'd0, bus.busy}, 32'd0);

        repeat (3) tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
